// File: rtl/knn_voter.sv
// Majority-vote reader for the k-NN sorter: walks neighbour ranks, fetches labels, tallies, resolves the winner.
// Optional build macro KNN_VOTE_WEIGHT_EN: rank r votes with weight K-r instead of 1.
module knn_voter #(
  parameter int K       = 4,
  parameter int IDX_W   = 8,
  parameter int LABEL_W = 8,
  parameter int NCLASS  = 10,
  parameter int CNT_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [1:0]         sel,
  input  logic [IDX_W-1:0]   idx_in,
  output logic               lbl_rd,
  output logic [IDX_W-1:0]   lbl_addr,
  input  logic [LABEL_W-1:0] lbl_data,
  output logic               busy,
  output logic               done,
  output logic [LABEL_W-1:0] label,
  output logic               invalid
);

  localparam int CLS_W = (NCLASS > 1) ? $clog2(NCLASS) : 1;

  typedef enum logic [2:0] {IDLE, READ, DRAIN, RESOLVE, DONE} state_t;

  state_t               state_reg;
  logic                 acc_en_reg;
  logic [1:0]           acc_rank_reg;
  logic [CLS_W-1:0]     cls_reg;
  logic [CNT_W-1:0]     max_reg;
  logic [LABEL_W-1:0]   arg_reg;
  logic [LABEL_W-1:0]   nearest_reg;
  logic                 nearest_valid_reg;
  logic [CNT_W-1:0]     cnt_reg [NCLASS];

  logic [CNT_W-1:0]     weight;
  logic [CNT_W-1:0]     cur_cnt;
  logic [CNT_W-1:0]     near_cnt;
  logic [CNT_W-1:0]     max_next;
  logic [LABEL_W-1:0]   arg_next;
  logic                 accept;

  assign accept   = (state_reg == IDLE) && start;
  // The sorter's DATA_OUT follows sel combinationally, so the address is simply forwarded.
  assign lbl_addr = lbl_rd ? idx_in : '0;

`ifdef KNN_VOTE_WEIGHT_EN
  assign weight = CNT_W'(K) - CNT_W'(acc_rank_reg);
`else
  assign weight = CNT_W'(1);
`endif

  // One saturating tally per class; labels outside 0..NCLASS-1 match no counter.
  genvar gi;
  generate
    for (gi = 0; gi < NCLASS; gi++) begin : g_cnt
      logic [CNT_W:0] sum_next;
      assign sum_next = {1'b0, cnt_reg[gi]} + {1'b0, weight};
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_reg[gi] <= '0;
        end else if (accept) begin
          cnt_reg[gi] <= '0;
        end else if (acc_en_reg && (lbl_data == LABEL_W'(gi))) begin
          cnt_reg[gi] <= sum_next[CNT_W] ? '1 : sum_next[CNT_W-1:0];
        end
      end
    end
  endgenerate

  always_comb begin
    cur_cnt  = '0;
    near_cnt = '0;
    for (int i = 0; i < NCLASS; i++) begin
      if (CLS_W'(i) == cls_reg)       cur_cnt  = cnt_reg[i];
      if (LABEL_W'(i) == nearest_reg) near_cnt = cnt_reg[i];
    end
    // Strict compare keeps the lowest class index on equal counts.
    max_next = max_reg;
    arg_next = arg_reg;
    if (cur_cnt > max_reg) begin
      max_next = cur_cnt;
      arg_next = LABEL_W'(cls_reg);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg         <= IDLE;
      sel               <= '0;
      lbl_rd            <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      label             <= '0;
      invalid           <= 1'b0;
      acc_en_reg        <= 1'b0;
      acc_rank_reg      <= '0;
      cls_reg           <= '0;
      max_reg           <= '0;
      arg_reg           <= '0;
      nearest_reg       <= '0;
      nearest_valid_reg <= 1'b0;
    end else begin
      acc_en_reg   <= (state_reg == READ);
      acc_rank_reg <= sel;
      if (acc_en_reg && (acc_rank_reg == 2'd0)) begin
        nearest_reg       <= lbl_data;
        nearest_valid_reg <= (lbl_data < LABEL_W'(NCLASS));
      end
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg         <= READ;
            sel               <= '0;
            lbl_rd            <= 1'b1;
            busy              <= 1'b1;
            cls_reg           <= '0;
            max_reg           <= '0;
            arg_reg           <= '0;
            nearest_valid_reg <= 1'b0;
          end
        end
        READ: begin
          if (sel == 2'(K - 1)) begin
            state_reg <= DRAIN;
            sel       <= '0;
            lbl_rd    <= 1'b0;
          end else begin
            sel <= sel + 2'd1;
          end
        end
        DRAIN: begin
          state_reg <= RESOLVE;
        end
        RESOLVE: begin
          max_reg <= max_next;
          arg_reg <= arg_next;
          cls_reg <= cls_reg + CLS_W'(1);
          if (cls_reg == CLS_W'(NCLASS - 1)) begin
            state_reg <= DONE;
            done      <= 1'b1;
            if (max_next == '0) begin
              label   <= '0;
              invalid <= 1'b1;
            end else begin
              invalid <= 1'b0;
              label   <= (nearest_valid_reg && (near_cnt == max_next)) ? nearest_reg : arg_next;
            end
          end
        end
        DONE: begin
          state_reg <= IDLE;
          done      <= 1'b0;
          busy      <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_knn_voter.sv
// Self-checking bench for knn_voter: directed and random label sets against a plain vote-counting model.
module tb_knn_voter;
  localparam int K = 4, IDX_W = 8, LABEL_W = 8, NCLASS = 10, CNT_W = 4;

  logic               clk = 1'b0;
  logic               rst, start;
  logic [1:0]         sel;
  logic [IDX_W-1:0]   idx_in;
  logic               lbl_rd;
  logic [IDX_W-1:0]   lbl_addr;
  logic [LABEL_W-1:0] lbl_data = '0;
  logic               busy, done, invalid;
  logic [LABEL_W-1:0] label;

  logic [IDX_W-1:0]   nbr [K];
  logic [LABEL_W-1:0] mem [256];
  int tests = 0;
  int fails = 0;

  knn_voter #(.K(K), .IDX_W(IDX_W), .LABEL_W(LABEL_W), .NCLASS(NCLASS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .sel(sel), .idx_in(idx_in), .lbl_rd(lbl_rd),
    .lbl_addr(lbl_addr), .lbl_data(lbl_data), .busy(busy), .done(done), .label(label),
    .invalid(invalid)
  );

  always #5 clk = ~clk;

  assign idx_in = nbr[sel];
  always @(posedge clk) if (lbl_rd) lbl_data <= mem[lbl_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Vote model: tally by rank with saturation, then apply the nearest-first tie rule.
  function automatic void ref_vote(input int lab [K], output int win, output int inv);
    int cnt [NCLASS];
    int mx, w;
    int sat;
    sat = (1 << CNT_W) - 1;
    mx = 0;
    for (int c = 0; c < NCLASS; c++) cnt[c] = 0;
    for (int r = 0; r < K; r++) begin
`ifdef KNN_VOTE_WEIGHT_EN
      w = K - r;
`else
      w = 1;
`endif
      if (lab[r] < NCLASS) cnt[lab[r]] = (cnt[lab[r]] + w > sat) ? sat : cnt[lab[r]] + w;
    end
    for (int c = 0; c < NCLASS; c++) if (cnt[c] > mx) mx = cnt[c];
    win = 0;
    inv = (mx == 0);
    if (mx != 0) begin
      if (lab[0] < NCLASS && cnt[lab[0]] == mx) win = lab[0];
      else begin
        for (int c = NCLASS - 1; c >= 0; c--) if (cnt[c] == mx) win = c;
      end
    end
  endfunction

  task automatic run(input int lab [K], input string tag, input bit restart_mid);
    int base, done_c, ew, ei;
    base = int'($urandom_range(0, 255));
    for (int r = 0; r < K; r++) begin
      nbr[r] = IDX_W'(base + r * 61);
      mem[nbr[r]] = LABEL_W'(lab[r]);
    end
    ref_vote(lab, ew, ei);
    done_c = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (restart_mid && c == 2) start = 1'b1;
      if (restart_mid && c == 3) start = 1'b0;
      if (c == 1) chk({tag, " busy"}, busy, 1);
      if (c <= K) begin
        chk({tag, " sel"}, sel, c - 1);
        chk({tag, " lbl_rd"}, lbl_rd, 1);
        chk({tag, " lbl_addr"}, lbl_addr, nbr[c-1]);
      end
      if (done === 1'b1) begin
        done_c = c;
        break;
      end
    end
    chk({tag, " done_cycle"}, done_c, 16);
    chk({tag, " label"}, label, ew);
    chk({tag, " invalid"}, invalid, ei);
    $display("[TB] %s labels {%0d,%0d,%0d,%0d} -> label %0d invalid %0d done cycle %0d",
             tag, lab[0], lab[1], lab[2], lab[3], label, invalid, done_c);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk({tag, " no_extra_done"}, done, 0);
    end
    chk({tag, " idle_busy"}, busy, 0);
    chk({tag, " idle_sel"}, sel, 0);
    chk({tag, " idle_lbl_rd"}, lbl_rd, 0);
    chk({tag, " label_held"}, label, ew);
  endtask

  initial begin
    int l [K];
    rst = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    for (int r = 0; r < K; r++) nbr[r] = '0;
    @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset label", label, 0);
    chk("reset invalid", invalid, 0);
    chk("reset sel", sel, 0);
    chk("reset lbl_rd", lbl_rd, 0);
    @(negedge clk);
    rst = 1'b0;

    l = '{3, 3, 5, 7};      run(l, "majority", 1'b0);
    l = '{5, 3, 3, 5};      run(l, "tie_nearest", 1'b0);
    l = '{2, 3, 3, 5};      run(l, "clear_max", 1'b0);
    l = '{1, 2, 3, 4};      run(l, "all_one", 1'b0);
    l = '{4, 2, 2, 9};      run(l, "weight_case", 1'b0);
    l = '{12, 15, 200, 10}; run(l, "all_invalid", 1'b0);
    l = '{12, 6, 6, 6};     run(l, "near_invalid", 1'b0);
    l = '{0, 9, 9, 0};      run(l, "edge_classes", 1'b0);
    l = '{7, 7, 7, 7};      run(l, "restart_ignored", 1'b1);
    l = '{8, 8, 8, 8};      run(l, "back_to_back", 1'b0);

    // Reset in the middle of the class scan.
    l = '{6, 6, 1, 1};
    for (int r = 0; r < K; r++) begin
      nbr[r] = IDX_W'(r * 3);
      mem[nbr[r]] = LABEL_W'(l[r]);
    end
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst busy", busy, 0);
    chk("midrst done", done, 0);
    chk("midrst label", label, 0);
    chk("midrst invalid", invalid, 0);
    chk("midrst sel", sel, 0);
    $display("[TB] reset asserted during resolve: busy %0d done %0d label %0d", busy, done, label);
    @(negedge clk);
    rst = 1'b0;
    l = '{3, 3, 5, 7}; run(l, "after_reset", 1'b0);

    for (int t = 0; t < 12; t++) begin
      for (int r = 0; r < K; r++) l[r] = ($urandom_range(0, 5) == 0) ? int'($urandom_range(10, 255))
                                                                      : int'($urandom_range(0, 9));
      run(l, $sformatf("rand%0d", t), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
